// File: rtl/io_supply_sequencer.sv
// Staggered power-up / reverse power-down sequencer for the IO pad ring supply segments.
// Waits on each segment's synchronized power-good, supervises the enabled segments and latches faults.
module io_supply_sequencer #(
    parameter int N_CH    = 4,
    parameter int STAGGER = 16,
    parameter int TIMEOUT = 256,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_req,
    input  logic [N_CH-1:0] pg_in,
    input  logic            fault_clr,
    output logic [N_CH-1:0] pwr_en,
    output logic            ready,
    output logic            busy,
    output logic            fault,
    output logic [CH_W-1:0] fault_ch
);

    localparam int CNT_MAX = (STAGGER > TIMEOUT) ? STAGGER : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {OFF, UP_WAIT, UP_GAP, ON, DN, FAULT} state_t;

    state_t          state;
    logic [CH_W-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  pg_meta;
    logic [N_CH-1:0]  pg_s;
    logic [N_CH-1:0]  bad;
    logic [CH_W-1:0]  bad_idx;

    // pg_in is asynchronous to clk, so it only ever reaches the FSM through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pg_meta <= '0;
            pg_s    <= '0;
        end else begin
            pg_meta <= pg_in;
            pg_s    <= pg_meta;
        end
    end

    assign bad = pwr_en & ~pg_s;

    // Lowest enabled segment that has lost power-good.
    always_comb begin
        bad_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bad[i]) bad_idx = CH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            idx      <= '0;
            cnt      <= '0;
            pwr_en   <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            fault_ch <= '0;
        end else begin
            case (state)
                OFF: begin
                    if (up_req) begin
                        pwr_en <= N_CH'(1);
                        idx    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= UP_WAIT;
                    end
                end
                UP_WAIT: begin
                    if (!up_req) begin
                        pwr_en[idx] <= 1'b0;
                        cnt         <= '0;
                        state       <= DN;
                    end else if (pg_s[idx]) begin
                        cnt   <= '0;
                        state <= UP_GAP;
                    end else if (cnt == TO_LAST) begin
                        pwr_en   <= '0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                        fault_ch <= idx;
                        state    <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Supervision outranks both the abort request and the stagger counter.
                UP_GAP: begin
                    if (|bad) begin
                        pwr_en   <= '0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                        fault_ch <= bad_idx;
                        state    <= FAULT;
                    end else if (!up_req) begin
                        pwr_en[idx] <= 1'b0;
                        cnt         <= '0;
                        state       <= DN;
                    end else if (cnt == GAP_LAST) begin
                        if (idx == LAST_CH) begin
                            busy  <= 1'b0;
                            ready <= 1'b1;
                            state <= ON;
                        end else begin
                            idx                  <= idx + 1'b1;
                            pwr_en[idx + 1'b1]   <= 1'b1;
                            cnt                  <= '0;
                            state                <= UP_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (|bad) begin
                        pwr_en   <= '0;
                        ready    <= 1'b0;
                        fault    <= 1'b1;
                        fault_ch <= bad_idx;
                        state    <= FAULT;
                    end else if (!up_req) begin
                        pwr_en[N_CH-1] <= 1'b0;
                        idx            <= LAST_CH;
                        cnt            <= '0;
                        ready          <= 1'b0;
                        busy           <= 1'b1;
                        state          <= DN;
                    end
                end
                // Teardown runs to completion; up_req is deliberately ignored here.
                DN: begin
                    if (cnt == GAP_LAST) begin
                        if (idx == '0) begin
                            busy  <= 1'b0;
                            state <= OFF;
                        end else begin
                            idx                <= idx - 1'b1;
                            pwr_en[idx - 1'b1] <= 1'b0;
                            cnt                <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FAULT: begin
                    if (fault_clr && !up_req) begin
                        fault    <= 1'b0;
                        fault_ch <= '0;
                        idx      <= '0;
                        cnt      <= '0;
                        state    <= OFF;
                    end
                end
                default: begin
                    pwr_en <= '0;
                    ready  <= 1'b0;
                    busy   <= 1'b0;
                    fault  <= 1'b0;
                    state  <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_supply_sequencer.sv
// Self-checking bench for io_supply_sequencer; expected timelines come from arithmetic on
// segment enable edges, stagger and timeout rather than from a cycle-level copy of the FSM.
module tb_io_supply_sequencer;

    localparam int N_CH    = 4;
    localparam int STAGGER = 4;
    localparam int TIMEOUT = 8;
    localparam int CH_W    = 2;

    typedef logic [N_CH+CH_W+2:0] snap_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            up_req;
    logic [N_CH-1:0] pg_in;
    logic            fault_clr;
    logic [N_CH-1:0] pwr_en;
    logic            ready;
    logic            busy;
    logic            fault;
    logic [CH_W-1:0] fault_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_supply_sequencer #(
        .N_CH(N_CH),
        .STAGGER(STAGGER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_req(up_req),
        .pg_in(pg_in),
        .fault_clr(fault_clr),
        .pwr_en(pwr_en),
        .ready(ready),
        .busy(busy),
        .fault(fault),
        .fault_ch(fault_ch)
    );

    function automatic snap_t pack(input logic [N_CH-1:0] en, input logic rdy, input logic bsy,
                                   input logic flt, input logic [CH_W-1:0] ch);
        return {en, rdy, bsy, flt, ch};
    endfunction

    // Observed outputs packed as {pwr_en, ready, busy, fault, fault_ch}.
    wire snap_t obs = {pwr_en, ready, busy, fault, fault_ch};

    task automatic do_reset(input logic [N_CH-1:0] pg);
        @(negedge clk);
        rst = 1'b1; up_req = 1'b0; fault_clr = 1'b0; pg_in = pg;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; up_req = 1'b1; fault_clr = 1'b0; pg_in = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack('0, 0, 0, 0, '0)) begin
                errors++;
                $display("[TB] FAIL reset k=%0d got %b want %b", k, obs, pack('0, 0, 0, 0, '0));
            end
        end
        rst = 1'b0; up_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== pack('0, 0, 0, 0, '0)) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got %b want %b", obs, pack('0, 0, 0, 0, '0));
        end
    endtask

    // Power-good already high: segment i enabled at i*(STAGGER+1), ready at N_CH*(STAGGER+1).
    task automatic test_powerup_nominal();
        snap_t exp;
        logic [N_CH-1:0] en;
        logic rdy;
        do_reset('1);
        up_req = 1'b1;
        for (int t = 0; t <= N_CH * (STAGGER + 1) + 2; t++) begin
            @(negedge clk);
            en = '0;
            for (int i = 0; i < N_CH; i++) if (i * (STAGGER + 1) <= t) en[i] = 1'b1;
            rdy = (t >= N_CH * (STAGGER + 1));
            exp = pack(en, rdy, !rdy, 0, '0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL powerup_nominal t=%0d got %b want %b", t, obs, exp);
            end
        end
    endtask

    // Continues from ON: segment N_CH-1-k clears at d+k*STAGGER, idle at d+N_CH*STAGGER.
    task automatic test_powerdown();
        snap_t exp;
        logic [N_CH-1:0] en;
        up_req = 1'b0;
        for (int j = 0; j <= N_CH * STAGGER + 2; j++) begin
            @(negedge clk);
            en = '0;
            for (int i = 0; i < N_CH; i++) if ((N_CH - 1 - i) * STAGGER > j) en[i] = 1'b1;
            exp = pack(en, 0, (j < N_CH * STAGGER), 0, '0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL powerdown j=%0d got %b want %b", j, obs, exp);
            end
        end
    endtask

    task automatic test_timeout();
        snap_t exp;
        logic [N_CH-1:0] en;
        do_reset(4'hD);
        up_req = 1'b1;
        for (int t = 0; t <= STAGGER + 1 + TIMEOUT + 2; t++) begin
            @(negedge clk);
            if (t >= STAGGER + 1 + TIMEOUT) begin
                exp = pack('0, 0, 0, 1, CH_W'(1));
            end else begin
                en = (t >= STAGGER + 1) ? 4'h3 : 4'h1;
                exp = pack(en, 0, 1, 0, '0);
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL timeout t=%0d got %b want %b", t, obs, exp);
            end
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs !== pack('0, 0, 0, 1, CH_W'(1))) begin
                errors++;
                $display("[TB] FAIL clr_ignored k=%0d got %b want %b", k, obs, pack('0, 0, 0, 1, CH_W'(1)));
            end
            @(negedge clk);
        end
        up_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== pack('0, 0, 0, 1, CH_W'(1))) begin
            errors++;
            $display("[TB] FAIL fault_held got %b want %b", obs, pack('0, 0, 0, 1, CH_W'(1)));
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (obs !== pack('0, 0, 0, 0, '0)) begin
            errors++;
            $display("[TB] FAIL fault_clear got %b want %b", obs, pack('0, 0, 0, 0, '0));
        end
        up_req = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== pack(4'h1, 0, 1, 0, '0)) begin
            errors++;
            $display("[TB] FAIL restart_after_clear got %b want %b", obs, pack(4'h1, 0, 1, 0, '0));
        end
    endtask

    // Plant raises pg_in[i] D cycles after its enable; the FSM sees it D+3 edges after enable.
    task automatic test_powerup_random();
        int d[N_CH];
        int en_t[N_CH];
        int t, nseg, fault_t, fault_idx, ready_t, end_t;
        snap_t exp;
        logic [N_CH-1:0] en;
        logic rdy;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_CH; i++)
                d[i] = ($urandom_range(0, 9) == 0) ? 6 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 5));
            t = 0; nseg = N_CH; fault_t = -1; fault_idx = 0; ready_t = -1;
            for (int i = 0; i < N_CH; i++) begin
                en_t[i] = t;
                if (d[i] + 3 > TIMEOUT) begin
                    fault_t = t + TIMEOUT; fault_idx = i; nseg = i + 1;
                    break;
                end
                t = t + d[i] + 3 + STAGGER;
            end
            if (fault_t < 0) ready_t = t;
            end_t = ((fault_t >= 0) ? fault_t : ready_t) + 2;
            do_reset('0);
            up_req = 1'b1;
            for (int tt = 0; tt <= end_t; tt++) begin
                @(negedge clk);
                if (fault_t >= 0 && tt >= fault_t) begin
                    exp = pack('0, 0, 0, 1, CH_W'(fault_idx));
                end else begin
                    en = '0;
                    for (int i = 0; i < nseg; i++) if (en_t[i] <= tt) en[i] = 1'b1;
                    rdy = (ready_t >= 0 && tt >= ready_t);
                    exp = pack(en, rdy, !rdy, 0, '0);
                end
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL powerup_random it=%0d t=%0d got %b want %b", it, tt, obs, exp);
                end
                for (int i = 0; i < nseg; i++) if (tt == en_t[i] + d[i]) pg_in[i] = 1'b1;
            end
        end
    endtask

    task automatic test_supervision();
        logic [N_CH-1:0] mask;
        int low;
        snap_t exp;
        for (int it = 0; it < 6; it++) begin
            mask = (it == 0) ? 4'hC : N_CH'($urandom_range(1, (1 << N_CH) - 1));
            low = 0;
            while (!mask[low]) low++;
            do_reset('1);
            up_req = 1'b1;
            repeat (N_CH * (STAGGER + 1) + 1) @(negedge clk);
            checks++;
            if (obs !== pack('1, 1, 0, 0, '0)) begin
                errors++;
                $display("[TB] FAIL reach_on it=%0d got %b want %b", it, obs, pack('1, 1, 0, 0, '0));
            end
            pg_in = ~mask;
            for (int e = 1; e <= 4; e++) begin
                @(negedge clk);
                pg_in = '1;
                exp = (e >= 3) ? pack('0, 0, 0, 1, CH_W'(low)) : pack('1, 1, 0, 0, '0);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL supervision mask=%h e=%0d got %b want %b", mask, e, obs, exp);
                end
            end
        end
    endtask

    // Abort during UP_GAP of segment 1: segment 1 drops at once, segment 0 STAGGER later.
    task automatic test_abort();
        int t_drop, a;
        snap_t exp;
        logic [N_CH-1:0] en;
        for (int it = 0; it < 3; it++) begin
            t_drop = STAGGER + 2 + int'($urandom_range(0, STAGGER - 1));
            a = t_drop + 1;
            do_reset('1);
            up_req = 1'b1;
            for (int t = 0; t <= a + 2 * STAGGER + 2; t++) begin
                @(negedge clk);
                if (t < a) begin
                    en = (t >= STAGGER + 1) ? 4'h3 : 4'h1;
                    exp = pack(en, 0, 1, 0, '0);
                end else begin
                    en = (t - a < STAGGER) ? 4'h1 : 4'h0;
                    exp = pack(en, 0, (t - a < 2 * STAGGER), 0, '0);
                end
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL abort drop=%0d t=%0d got %b want %b", t_drop, t, obs, exp);
                end
                if (t == t_drop) up_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midway();
        snap_t exp;
        do_reset('1);
        up_req = 1'b1;
        repeat ($urandom_range(6, 17)) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack('0, 0, 0, 0, '0)) begin
                errors++;
                $display("[TB] FAIL reset_midway k=%0d got %b want %b", k, obs, pack('0, 0, 0, 0, '0));
            end
        end
        rst = 1'b0;
        for (int t = 0; t <= STAGGER + 3; t++) begin
            @(negedge clk);
            exp = pack((t >= STAGGER + 2) ? 4'h3 : 4'h1, 0, 1, 0, '0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL restart t=%0d got %b want %b", t, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; up_req = 1'b0; fault_clr = 1'b0; pg_in = '0;
        test_reset();
        test_powerup_nominal();
        test_powerdown();
        test_timeout();
        test_powerup_random();
        test_supervision();
        test_abort();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/io_supply_sequencer.md
# io_supply_sequencer

Parametrised power-up/power-down sequencer for the IO pad ring supply segments. It drives the enable of N_CH switched IO supply segments one at a time with a programmable stagger, which limits inrush current. It waits for each segment's power-good before moving on and tears the segments down in reverse order. It supervises power-good continuously and collapses all segments on a fault. It sits between the chip power controller and the IO supply pad switch cells.

## Interface
- `N_CH`, 4: number of supply segments; must be ≥1.
- `STAGGER`, 16: gap in cycles between segment steps; must be ≥1.
- `TIMEOUT`, 256: maximum cycles to wait for a segment's power-good; must be ≥2.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `up_req` in 1: level input; 1 requests all segments on, 0 requests all segments off.
- `pg_in` in N_CH: per-segment power-good, asynchronous to `clk`.
- `fault_clr` in 1: single-cycle pulse that acknowledges a fault.
- `pwr_en` out N_CH: per-segment switch enable.
- `ready` out 1: all segments on and good.
- `busy` out 1: a sequencing operation is in progress.
- `fault` out 1: sequencer is latched in FAULT.
- `fault_ch` out CH_W: index of the faulting segment; CH_W = max(1, clog2(N_CH)).

## Operation
- Each `pg_in` bit passes through a 2-flop synchronizer (reset 0); the result is `pg_s`. All decisions use `pg_s` only.
- Internal state: segment index `idx`, and a step counter `cnt` of width clog2(max(STAGGER, TIMEOUT)).
- All outputs are registered. On reset: `pwr_en`=0, `ready`=0, `busy`=0, `fault`=0, `fault_ch`=0, state OFF, `idx`=0, `cnt`=0.
- `busy`=1 in UP_WAIT, UP_GAP and DN. `ready`=1 only in ON. `fault`=1 only in FAULT.
- OFF:
  - `up_req`=1 → set `pwr_en[0]`, `idx`=0, `cnt`=0, go to UP_WAIT.
- UP_WAIT:
  - If `pg_s[idx]`=1 → `cnt`=0, go to UP_GAP.
  - Else if `cnt`=TIMEOUT-1 → go to FAULT with `fault_ch`=`idx`.
  - Else `cnt`++.
- UP_GAP:
  - If `cnt`=STAGGER-1 and `idx`=N_CH-1 → go to ON.
  - If `cnt`=STAGGER-1 and `idx`<N_CH-1 → `idx`++, set `pwr_en[idx+1]`, `cnt`=0, go to UP_WAIT.
  - Otherwise `cnt`++.
- ON: `up_req`=0 → clear `pwr_en[N_CH-1]`, `idx`=N_CH-1, `cnt`=0, go to DN.
- Abort: `up_req`=0 in UP_WAIT or UP_GAP → clear `pwr_en[idx]`, `cnt`=0, go to DN. Teardown starts from the current `idx`.
- DN:
  - If `cnt`=STAGGER-1 and `idx`=0 → go to OFF.
  - If `cnt`=STAGGER-1 and `idx`>0 → `idx`--, clear `pwr_en[idx-1]`, `cnt`=0.
  - Otherwise `cnt`++.
  - `up_req` is ignored in DN; a new power-up starts only from OFF.
- Supervision:
  - In UP_GAP and ON, if any bit with `pwr_en`=1 has `pg_s`=0 → go to FAULT. `fault_ch` = lowest such index.
  - Supervision has priority over `up_req` and over counter transitions.
  - No supervision in DN.
- FAULT:
  - All `pwr_en` bits clear on entry, simultaneously; `fault_ch` is held.
  - `fault_clr`=1 and `up_req`=0 → go to OFF and clear `fault`, `fault_ch` and `idx`.
  - `fault_clr` while `up_req`=1 is ignored.

## Timing
- Edge 0 is the edge at which OFF first samples `up_req`=1. `pwr_en[0]` rises at edge 0.
- Power-up, with `pg_s` already high: segment i is enabled at edge i·(STAGGER+1), and `ready` rises at edge N_CH·(STAGGER+1).
- Power-up with an added power-good delay: a segment whose `pg_in` rises late adds its wait cycles plus 2 synchronizer cycles to every later step.
- Power-down: edge d is the edge at which `up_req`=0 is sampled in ON. Segment N_CH-1-k clears at edge d+k·STAGGER. `busy` falls and the state is OFF at edge d+N_CH·STAGGER.
- Timeout: FAULT is entered TIMEOUT edges after the segment's enable edge.
- Fault in UP_GAP or ON: `pwr_en` clears 1 edge after `pg_s` is seen low. That is 3 edges after `pg_in` falls.
- Reset mid-operation: asserting `rst` clears every output at the next edge, with no sequenced teardown.

## Test plan
- Parameters N_CH=4, STAGGER=4, TIMEOUT=8; `pg_in`=4'hF held; raise `up_req` → `pwr_en` rises at edges 0, 5, 10 and 15 (1, 3, 7, F); `ready`=1 from edge 20; `busy`=1 between those points.
- From ON, drop `up_req` → `pwr_en` goes 7, 3, 1, 0 at edges d, d+4, d+8, d+12; `busy`=0 at d+16.
- `pg_in[1]` held 0 during power-up → `fault`=1, `fault_ch`=1 and `pwr_en`=0 at edge 13. `fault_clr` with `up_req`=1 → no change. Then drop `up_req` and pulse `fault_clr` → OFF with `fault`=0.
- In ON, pulse `pg_in[2]` and `pg_in[3]` low together → `fault`=1, `fault_ch`=2 and `pwr_en`=0, three edges after the fall.
- Drop `up_req` during UP_GAP of segment 1 → `pwr_en` goes 1 at that edge, then 0 four edges later, then OFF.
- Assert `rst` in the middle of power-up → all outputs 0 at the next edge. Power-up restarts from segment 0 once `rst` is released.
